fpga_config_loader: RTL
=======================

# fpga_config_loader

Bitstream loader sitting directly upstream of the fabric tile array. Accepts configuration words over a valid/ready stream and serialises them, LSB first, into the fabric's two scan chains: the CLB chain first, then the connection chain (SB → CB top → CB right per tile). Holds the fabric in reset while loading and releases it once both chains are full. At top level the fabric's `scan_clk` is tied to `clk`, so one scan bit is shifted per `clk` cycle in which the matching `*_scan_en` is high.

## Interface
- `WORD_WIDTH`, 8, config word width in bits
- `CLB_CHAIN_LEN`, 10, total bits in the concatenated CLB scan chain (≥1)
- `CONN_CHAIN_LEN`, 6, total bits in the concatenated connection scan chain (≥1)
- `CNT_WIDTH`, 16, bit-counter width; must hold max(CLB_CHAIN_LEN, CONN_CHAIN_LEN)

- `clk`  in  1  sole clock; synchronous reset, active-high
- `reset`  in  1  synchronous, active-high
- `start`  in  1  single-cycle request to begin a load
- `cfg_data`  in  WORD_WIDTH  configuration word
- `cfg_valid`  in  1  `cfg_data` valid
- `cfg_ready`  out  1  loader accepts a word this cycle
- `clb_scan_in`  out  1  serial data to CLB chain
- `clb_scan_en`  out  1  shift enable, CLB chain
- `conn_scan_in`  out  1  serial data to connection chain
- `conn_scan_en`  out  1  shift enable, connection chain
- `fabric_reset`  out  1  reset to fabric user logic
- `busy`  out  1  load in progress
- `done`  out  1  both chains loaded

## Operation
- States: IDLE, LOAD_CLB, LOAD_CONN, DONE. Two-bit state register.
- IDLE/DONE + `start` → LOAD_CLB next cycle; `fabric_reset`←1, `done`←0, `busy`←1, counters cleared. `start` ignored in LOAD_CLB/LOAD_CONN.
- Word shift register plus valid flag; word bit index (clog2(WORD_WIDTH) bits); chain bit counter (CNT_WIDTH).
- A word is accepted on `cfg_valid && cfg_ready`. `cfg_ready` = LOAD state AND (shift register empty OR this cycle shifts the last bit of the word OR this cycle shifts the last bit of the current chain). Zero-bubble streaming when `cfg_valid` held high.
- Each cycle with a loaded word: drive the current bit on the active chain's `*_scan_in`, its `*_scan_en`=1, increment both counters. Inactive chain: `scan_in`=0, `scan_en`=0.
- Underrun (no word available): active `scan_en`=0, chain holds; no error, loader waits indefinitely.
- Chain boundary: when the chain counter reaches CLB_CHAIN_LEN, remaining bits of the current word are discarded; LOAD_CONN starts with a fresh word. Hence CLB needs ceil(CLB_CHAIN_LEN/WORD_WIDTH) words, connection chain ceil(CONN_CHAIN_LEN/WORD_WIDTH).
- Last connection bit shifted → DONE: `fabric_reset`←0, `done`←1, `busy`←0. `cfg_ready`=0 in IDLE/DONE.
- Counters compare with `==` against LEN−1; no wrap occurs within a load.

## Timing
- Reset values: `cfg_ready`=0, `clb_scan_in`=0, `clb_scan_en`=0, `conn_scan_in`=0, `conn_scan_en`=0, `fabric_reset`=1, `busy`=0, `done`=0; state IDLE; shift register invalid.
- All outputs except `cfg_ready` are registered; `cfg_ready` is a combinational function of registered state only (not of `cfg_valid`).
- Latency: word accepted in cycle N → its bit 0 appears on `*_scan_in` with `*_scan_en`=1 in cycle N+1.
- `start` in cycle 0 → `cfg_ready`=1, `busy`=1 in cycle 1.
- Last connection bit in cycle M → `done`=1, `fabric_reset`=0 in cycle M+1.
- `reset` mid-load: next cycle all outputs at reset values, pending word dropped, chain contents undefined; a new `start` is required.
- `reset` and `start` in same cycle: reset wins.

## Test plan
- Defaults, `start` cycle 0, `cfg_valid` held with words 0xA5, 0x03, 0x3C from cycle 1 → accepts in cycles 1, 9, 11; CLB bits 1,0,1,0,0,1,0,1,1,1 in cycles 2–11; conn bits 0,0,1,1,1,1 in cycles 12–17; `done`=1, `fabric_reset`=0 in cycle 18.
- Same data, `cfg_valid` low for 3 cycles before word 2 → `clb_scan_en` low exactly 3 cycles, no bit lost or duplicated, `done` 3 cycles later (cycle 21).
- Upper 6 bits of word 2 (0x03 → 0xFF) changed → chain contents identical to scenario 1 (discard rule).
- `reset` asserted in cycle 6 → cycle 7: all `scan_en`=0, `busy`=0, `fabric_reset`=1; `start` in cycle 10 reloads correctly from bit 0.
- `start` pulsed in cycle 5 during LOAD_CLB → ignored, bit sequence unchanged; `start` in DONE → `done`=0, `fabric_reset`=1 next cycle, full reload.
- Scan-model check: 2×2 tile chain model behind loader, random bitstream → shifted-out chain state matches bitstream bit-for-bit.

Source files
------------

// File: rtl/fpga_config_loader.sv
// Bitstream loader: streams config words LSB first into the CLB scan chain, then the
// connection scan chain, holding the fabric in reset until both chains are full.
module fpga_config_loader #(
  parameter int WORD_WIDTH     = 8,
  parameter int CLB_CHAIN_LEN  = 10,
  parameter int CONN_CHAIN_LEN = 6,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  clb_scan_in,
  output logic                  clb_scan_en,
  output logic                  conn_scan_in,
  output logic                  conn_scan_en,
  output logic                  fabric_reset,
  output logic                  busy,
  output logic                  done
);
  localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_CLB, LOAD_CONN, DONE} state_t;

  state_t                state, n_state;
  logic [WORD_WIDTH-1:0] sreg, n_sreg;
  logic                  sv, n_sv;
  logic [BW-1:0]         bidx, n_bidx;
  logic [CNT_WIDTH-1:0]  ccnt, n_ccnt;
  logic                  loading, last_bit, last_chain, accept, n_bit;

  // sreg[bidx] is the bit being shifted this cycle whenever sv is set.
  always_comb begin
    loading    = (state == LOAD_CLB) || (state == LOAD_CONN);
    last_bit   = sv && (bidx == BW'(WORD_WIDTH - 1));
    last_chain = sv && (ccnt == ((state == LOAD_CLB) ? CNT_WIDTH'(CLB_CHAIN_LEN - 1)
                                                     : CNT_WIDTH'(CONN_CHAIN_LEN - 1)));
    cfg_ready  = loading && (!sv || last_bit || last_chain);
    accept     = cfg_ready && cfg_valid;

    n_state = state;
    n_sreg  = sreg;
    n_sv    = sv;
    n_bidx  = bidx;
    n_ccnt  = ccnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          n_state = LOAD_CLB;
          n_sv    = 1'b0;
          n_bidx  = '0;
          n_ccnt  = '0;
        end
      end
      default: begin
        if (sv) begin
          n_bidx = bidx + BW'(1);
          n_ccnt = ccnt + CNT_WIDTH'(1);
          if (last_bit || last_chain) n_sv = 1'b0;
          // Chain full: leftover bits of the word are dropped, next chain starts fresh.
          if (last_chain) begin
            n_ccnt  = '0;
            n_state = (state == LOAD_CLB) ? LOAD_CONN : DONE;
          end
        end
        if (accept && (n_state != DONE)) begin
          n_sreg = cfg_data;
          n_sv   = 1'b1;
          n_bidx = '0;
        end
      end
    endcase
    n_bit = n_sreg[n_bidx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sreg         <= '0;
      sv           <= 1'b0;
      bidx         <= '0;
      ccnt         <= '0;
      clb_scan_in  <= 1'b0;
      clb_scan_en  <= 1'b0;
      conn_scan_in <= 1'b0;
      conn_scan_en <= 1'b0;
      fabric_reset <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= n_state;
      sreg         <= n_sreg;
      sv           <= n_sv;
      bidx         <= n_bidx;
      ccnt         <= n_ccnt;
      clb_scan_en  <= n_sv && (n_state == LOAD_CLB);
      clb_scan_in  <= n_sv && (n_state == LOAD_CLB) && n_bit;
      conn_scan_en <= n_sv && (n_state == LOAD_CONN);
      conn_scan_in <= n_sv && (n_state == LOAD_CONN) && n_bit;
      fabric_reset <= (n_state != DONE);
      busy         <= (n_state == LOAD_CLB) || (n_state == LOAD_CONN);
      done         <= (n_state == DONE);
    end
  end
endmodule
